// File: rtl/cpu32_run_ctrl_pkg.sv
// Shared encodings and widths for the cpu32 run/step/halt controller.
package cpu32_ctrl_pkg;

  localparam int CNT_W = 16;
  localparam logic [3:0] STOP_OPCODE = 4'hF;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_HALT  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_STOP     = 3'd1;
  localparam logic [2:0] CAUSE_BREAK    = 3'd2;
  localparam logic [2:0] CAUSE_STEPDONE = 3'd3;
  localparam logic [2:0] CAUSE_HOST     = 3'd4;

  // A STEP of zero instructions still executes one.
  function automatic logic [CNT_W-1:0] step_load(input logic [CNT_W-1:0] arg);
    return (arg == '0) ? CNT_W'(1) : arg;
  endfunction

endpackage

// File: rtl/cpu32_run_ctrl_if.sv
// Host command channel of the run controller.
interface cpu32_run_ctrl_if;
  import cpu32_ctrl_pkg::*;

  // A command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
  // the host holds cmd_op/cmd_arg stable while cmd_valid is high and not yet accepted.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/cpu32_run_ctrl_sat_counter16.sv
// Saturating up-counter with synchronous clear, used for the executed-instruction count.
module sat_counter16
  import cpu32_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu32_run_ctrl.sv
// Run/step/halt controller: holds cpu32 in reset, gates execution per cycle and
// halts on the stop opcode, a breakpoint, step exhaustion or a host request.
module cpu32_run_ctrl
  import cpu32_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int PC_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  cpu32_run_ctrl_if.slave  cmd,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [15:0]      code,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [2:0]       state,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             done
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [RW-1:0]    rst_cnt;
  logic             resume;
  logic [CNT_W-1:0] step_rem;

  logic accept, run_like, start_acc, halt_acc, clear_acc;
  logic stop_hit, bp_hit, step_done, halt_evt;
  logic [2:0] cause_nxt;
  logic unused_code;

  assign unused_code = ^code[11:0];

  assign cmd.cmd_ready = (state != ST_RST);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign run_like      = (state == ST_RUN) || (state == ST_STEP);
  assign start_acc     = accept && ((cmd.cmd_op == OP_RUN) || (cmd.cmd_op == OP_STEP)) &&
                         ((state == ST_IDLE) || (state == ST_HALTED));
  assign halt_acc      = accept && (cmd.cmd_op == OP_HALT) && run_like;
  assign clear_acc     = accept && (cmd.cmd_op == OP_CLEAR);

  // resume masks the breakpoint for one cycle so a restart can execute the bp address.
  assign stop_hit  = run_like && (code[15:12] == STOP_OPCODE);
  assign bp_hit    = run_like && bp_en && (pc == bp_addr) && !resume;
  assign cpu_en    = run_like && !stop_hit && !bp_hit && !halt_acc;
  assign step_done = (state == ST_STEP) && cpu_en && (step_rem == CNT_W'(1));
  assign halt_evt  = stop_hit || bp_hit || step_done || halt_acc;
  assign cpu_rst   = (state == ST_RST);

  always_comb begin
    cause_nxt = CAUSE_NONE;
    if (stop_hit)       cause_nxt = CAUSE_STOP;
    else if (bp_hit)    cause_nxt = CAUSE_BREAK;
    else if (step_done) cause_nxt = CAUSE_STEPDONE;
    else if (halt_acc)  cause_nxt = CAUSE_HOST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RST;
      rst_cnt    <= '0;
      resume     <= 1'b0;
      step_rem   <= '0;
      halt_cause <= CAUSE_NONE;
      done       <= 1'b0;
    end else begin
      done   <= 1'b0;
      resume <= start_acc;
      if ((state == ST_STEP) && cpu_en) step_rem <= step_rem - 1'b1;

      if (clear_acc) begin
        state      <= ST_RST;
        rst_cnt    <= '0;
        resume     <= 1'b0;
        step_rem   <= '0;
        halt_cause <= CAUSE_NONE;
      end else begin
        case (state)
          ST_RST: begin
            if (rst_cnt == RW'(RST_CYCLES - 1)) state <= ST_IDLE;
            else rst_cnt <= rst_cnt + 1'b1;
          end
          ST_IDLE, ST_HALTED: begin
            if (start_acc) begin
              if (cmd.cmd_op == OP_RUN) begin
                state <= ST_RUN;
              end else begin
                state    <= ST_STEP;
                step_rem <= step_load(cmd.cmd_arg);
              end
            end
          end
          ST_RUN, ST_STEP: begin
            if (halt_evt) begin
              state      <= ST_HALTED;
              halt_cause <= cause_nxt;
              done       <= 1'b1;
            end
          end
          default: state <= ST_RST;
        endcase
      end
    end
  end

  sat_counter16 u_instr_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (clear_acc),
    .inc   (cpu_en),
    .count (instr_cnt)
  );

endmodule

// File: doc/cpu32_run_ctrl.md
# cpu32_run_ctrl

Run/step/halt controller for the cpu32 core. It holds the core in reset, then releases it under host command. It gates instruction execution with a per-cycle enable and watches the fetched `code` for the stop opcode and a programmable breakpoint. It sits between the host/bench command interface and the cpu32 `power`/enable inputs, beside the program ROM fetch path (`pc` → `code`).

## Interface
Parameters:
- `RST_CYCLES`, 2: cycles the core is held in reset after `reset` or CLEAR (≥1).
- `PC_W`, 8: program counter width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: host command strobe.
- `cmd_ready` out 1: controller accepts a command this cycle.
- `cmd_op` in 2: 0 RUN, 1 STEP, 2 HALT, 3 CLEAR.
- `cmd_arg` in 16: STEP instruction count (0 treated as 1); ignored otherwise.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in PC_W: breakpoint PC.
- `pc` in PC_W: current core PC.
- `code` in 16: instruction at `pc` (ROM output).
- `cpu_rst` out 1: active-high core reset; integration drives cpu32 `power = ~cpu_rst`.
- `cpu_en` out 1: core executes the instruction at `pc` on this edge.
- `state` out 3: 0 RST, 1 IDLE, 2 RUN, 3 STEP, 4 HALTED.
- `halt_cause` out 3: 0 NONE, 1 STOP, 2 BREAK, 3 STEPDONE, 4 HOST.
- `instr_cnt` out 16: instructions executed since last RST, saturating at 16'hFFFF.
- `done` out 1: one-cycle pulse on entering HALTED.

## Operation
- **Reset values:**
  - `state`=RST, `cpu_rst`=1, `cpu_en`=0, `cmd_ready`=0.
  - `halt_cause`=NONE, `instr_cnt`=0, `done`=0.
  - Step counter and resume flag cleared.
- **RST:** `cpu_rst`=1 for RST_CYCLES cycles, then IDLE with `cpu_rst`=0.
- **Command acceptance:**
  - `cmd_ready`=1 in every state except RST.
  - Accept = `cmd_valid & cmd_ready`.
  - Commands illegal in the current state are accepted and ignored.
- **RUN** (from IDLE/HALTED) → RUN. **STEP N** (from IDLE/HALTED) → STEP, remaining count = max(N,1).
- **HALT** (from RUN/STEP) → HALTED with cause HOST. **CLEAR** (from any non-RST state) → RST, zeroing `instr_cnt` and `halt_cause`.
- **Hit conditions** (evaluated combinationally in RUN/STEP):
  - stop_hit = `code[15:12]==4'hF`.
  - bp_hit = `bp_en & pc==bp_addr & !resume`.
  - `resume` is 1 only in the first RUN/STEP cycle after acceptance, so execution can leave a breakpoint.
- **Enable:** `cpu_en` = (RUN|STEP) & !stop_hit & !bp_hit & !(HALT accepted this cycle). The stop instruction is never executed; `pc` stays on it.
- **Instruction counting:**
  - Each `cpu_en` cycle increments `instr_cnt` (saturating).
  - In STEP it also decrements the remaining count. When it reaches 0 after an executed instruction → HALTED with cause STEPDONE.
- **Halt priority** (same cycle): STOP > BREAK > STEPDONE > HOST. The winning cause is latched.
- **RUN/STEP from HALTED with cause STOP:** the stop is still present, so the controller re-halts on the first cycle with 0 instructions executed and `done` pulses again.
- **`reset` mid-operation** overrides everything and returns to the reset values.

## Timing
- Command accepted in cycle T → new state visible after the edge ending T. The first `cpu_en`=1 is in cycle T+1.
- `cpu_en` and hit detection are combinational from `pc`/`code` within the cycle; there is no pipeline delay.
- On a hit in cycle H, `cpu_en`=0 in H, `state`=HALTED from H+1, and `done`=1 only in H+1.
- The HALT command in cycle T suppresses `cpu_en` in T itself.
- `cmd_ready` goes high in the first IDLE cycle: cycle RST_CYCLES after the reset deassert edge.

## Structure
- Shared package `cpu32_ctrl_pkg` holds:
  - the `cmd_op`, `state` and `halt_cause` encodings;
  - `STOP_OPCODE`=4'hF;
  - the instruction-count width.
- One natural sub-module: `sat_counter16`, the saturating increment with clear, used for `instr_cnt`.
- The FSM, step down-counter and reset-hold counter stay inline.

## Test plan
- **Reset:** `reset` high 3 cycles, then low → `cpu_rst`=1 for 2 cycles, IDLE, `cmd_ready`=1, all other outputs 0.
- **Run to stop:** ROM with 5 ALU ops then 16'hF000, RUN → `cpu_en` for exactly 5 cycles, HALTED/STOP, `instr_cnt`=5, `pc`=5, one `done` pulse.
- **Step:** STEP `cmd_arg`=3 → 3 enabled cycles, HALTED/STEPDONE, `instr_cnt`=3. STEP `cmd_arg`=0 → exactly 1 instruction.
- **Breakpoint:** `bp_en`=1, `bp_addr`=4, RUN → halts with `pc`=4, cause BREAK. A second RUN executes pc 4 and continues to the stop.
- **Host halt and simultaneous events:**
  - HALT during RUN at cycle T → `cpu_en`=0 in T, cause HOST.
  - HALT in the same cycle as a stop_hit → cause STOP.
- **Clear and saturation:**
  - CLEAR mid-RUN → RST for 2 cycles, then `instr_cnt`=0, `halt_cause`=NONE.
  - A loop running over 65535 instructions → `instr_cnt` holds 16'hFFFF.
